// File: rtl/baud_gen_frac_if.sv
// Control and tick bundle between a UART Tx/Rx path and its fractional baud generator.
// The master side programs the divisor and consumes the ticks; the generator is the slave.
interface baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              enable;
  logic [DIV_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_load;
  logic              resync;
  logic              cfg_pending;
  logic              ovs_tick;
  logic              mid_tick;
  logic              bit_tick;

  modport master (
    output enable, cfg_int, cfg_frac, cfg_load, resync,
    input  cfg_pending, ovs_tick, mid_tick, bit_tick
  );

  modport slave (
    input  enable, cfg_int, cfg_frac, cfg_load, resync,
    output cfg_pending, ovs_tick, mid_tick, bit_tick
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional baud-tick generator: clock / (N + frac/2^FRAC_W) oversample tick,
// plus bit-rate and mid-bit ticks derived from an oversample counter.
module baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_INT  = 325,
  parameter int DEF_FRAC = 8
) (
  input logic            clock,
  input logic            reset_n,
  baud_gen_frac_if.slave bus
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST    = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID_PRE = OVS_W'(OVS / 2 - 1);

  // Terminal count of a period: clamped divisor minus one, plus one cycle on fraction carry.
  function automatic logic [DIV_W-1:0] period_tc(
    input logic [DIV_W-1:0]  int_v,
    input logic [FRAC_W-1:0] frac_v,
    input logic [FRAC_W-1:0] acc_v
  );
    logic [DIV_W-1:0] n_eff;
    logic [FRAC_W:0]  sum;
    n_eff = (int_v < DIV_W'(2)) ? DIV_W'(2) : int_v;
    sum   = {1'b0, acc_v} + {1'b0, frac_v};
    return n_eff - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
  endfunction

  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEF_FRAC);
  localparam logic [DIV_W-1:0]  RST_TC   = period_tc(RST_INT, RST_FRAC, '0);

  logic [DIV_W-1:0]  act_int_q,  act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  sh_int_q,   sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q,  sh_frac_d;
  logic              pending_q,  pending_d;
  logic [DIV_W-1:0]  cnt_q,      cnt_d;
  logic [DIV_W-1:0]  tc_q,       tc_d;
  logic [FRAC_W-1:0] acc_q,      acc_d;
  logic [OVS_W-1:0]  ovs_cnt_q,  ovs_cnt_d;
  logic              ovs_tick_q, ovs_tick_d;
  logic              mid_tick_q, mid_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              period_end;
  logic              apply;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_int_q  <= RST_INT;
      act_frac_q <= RST_FRAC;
      sh_int_q   <= RST_INT;
      sh_frac_q  <= RST_FRAC;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      tc_q       <= RST_TC;
      acc_q      <= '0;
      ovs_cnt_q  <= '0;
      ovs_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      tc_q       <= tc_d;
      acc_q      <= acc_d;
      ovs_cnt_q  <= ovs_cnt_d;
      ovs_tick_q <= ovs_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  always_comb begin
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    tc_d       = tc_q;
    acc_d      = acc_q;
    ovs_cnt_d  = ovs_cnt_q;
    ovs_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;

    period_end = bus.enable && !bus.resync && (cnt_q == tc_q);
    apply      = pending_q && (period_end || bus.resync || !bus.enable);

    if (apply) begin
      act_int_d  = sh_int_q;
      act_frac_d = sh_frac_q;
      pending_d  = 1'b0;
    end

    // A load coincident with an apply is kept for the next boundary.
    if (bus.cfg_load) begin
      sh_int_d  = bus.cfg_int;
      sh_frac_d = bus.cfg_frac;
      pending_d = 1'b1;
    end

    // The period length is latched at period start, so a mid-period apply never bends it.
    if (bus.resync) begin
      cnt_d     = '0;
      acc_d     = '0;
      ovs_cnt_d = '0;
      tc_d      = period_tc(act_int_d, act_frac_d, '0);
    end else if (bus.enable) begin
      if (period_end) begin
        cnt_d      = '0;
        acc_d      = acc_q + act_frac_q;
        ovs_tick_d = 1'b1;
        mid_tick_d = (ovs_cnt_q == OVS_MID_PRE);
        bit_tick_d = (ovs_cnt_q == OVS_LAST);
        ovs_cnt_d  = (ovs_cnt_q == OVS_LAST) ? '0 : ovs_cnt_q + OVS_W'(1);
        tc_d       = period_tc(act_int_d, act_frac_d, acc_d);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  assign bus.cfg_pending = pending_q;
  assign bus.ovs_tick    = ovs_tick_q;
  assign bus.mid_tick    = mid_tick_q;
  assign bus.bit_tick    = bit_tick_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: stimulus queues the expected tick cycles,
// a negedge monitor pops and compares them as the DUT produces ticks.
module tb_baud_gen_frac;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  typedef struct {
    int cyc;
    bit mid;
    bit bt;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_base   = 0;
  int   m_ovs    = 0;
  exp_t exp_q[$];

  int def_len[2]   = '{325, 326};
  int frac_len[16] = '{20, 20, 20, 20, 20, 21, 20, 20, 20, 20, 21, 20, 20, 20, 20, 21};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  baud_gen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bif ();

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_INT(325), .DEF_FRAC(8)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bif)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_tick(input int len);
    exp_t e;
    m_base += len;
    m_ovs   = (m_ovs + 1) % OVS;
    e.cyc   = m_base;
    e.mid   = (m_ovs == OVS / 2);
    e.bt    = (m_ovs == 0);
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    if (cyc > c) check("goto_late", cyc, c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(negedge clock);
      b--;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (bif.ovs_tick) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ovs_tick", cyc, -1);
      end else begin
        e = exp_q.pop_front();
        check("ovs_tick_cycle", cyc, e.cyc);
        check("mid_tick", int'(bif.mid_tick), int'(e.mid));
        check("bit_tick", int'(bif.bit_tick), int'(e.bt));
      end
    end else begin
      check("stray_mid_bit", int'({bif.mid_tick, bif.bit_tick}), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int tn;
    bif.enable   = 1'b1;
    bif.cfg_int  = '0;
    bif.cfg_frac = '0;
    bif.cfg_load = 1'b0;
    bif.resync   = 1'b0;

    // Reset state
    goto(2);
    check("rst_ovs_tick", int'(bif.ovs_tick), 0);
    check("rst_mid_tick", int'(bif.mid_tick), 0);
    check("rst_bit_tick", int'(bif.bit_tick), 0);
    check("rst_cfg_pending", int'(bif.cfg_pending), 0);
    goto(3);
    reset_n = 1'b1;
    m_base  = 3;
    m_ovs   = 0;

    // Default 325.5: periods alternate 325/326, one bit = 5208 cycles
    for (int i = 0; i < 32; i++) push_tick(def_len[i % 2]);
    drain(12000);

    // Load 10.0 mid-period: current 325 period finishes, then every 10 cycles
    t = m_base;
    goto(t + 5);
    check("pending_idle", int'(bif.cfg_pending), 0);
    bif.cfg_int  = 16'd10;
    bif.cfg_frac = 4'd0;
    bif.cfg_load = 1'b1;
    goto(t + 6);
    bif.cfg_load = 1'b0;
    check("pending_after_load", int'(bif.cfg_pending), 1);
    push_tick(325);
    tn = m_base;
    for (int i = 0; i < 32; i++) push_tick(10);
    goto(tn - 1);
    check("pending_before_boundary", int'(bif.cfg_pending), 1);
    goto(tn);
    check("pending_cleared_at_boundary", int'(bif.cfg_pending), 0);
    drain(1000);

    // Clamp: int=0 gives a 2-cycle period
    t = m_base;
    goto(t + 2);
    bif.cfg_int  = 16'd0;
    bif.cfg_load = 1'b1;
    goto(t + 3);
    bif.cfg_load = 1'b0;
    push_tick(10);
    for (int i = 0; i < 8; i++) push_tick(2);
    drain(200);

    // Clamp int=1, loaded on the same edge as an apply: stays pending one more period
    t = m_base;
    goto(t + 1);
    bif.cfg_int  = 16'd1;
    bif.cfg_load = 1'b1;
    for (int i = 0; i < 8; i++) push_tick(2);
    goto(t + 2);
    bif.cfg_load = 1'b0;
    check("pending_coincident_load", int'(bif.cfg_pending), 1);
    goto(t + 4);
    check("pending_applied_next", int'(bif.cfg_pending), 0);
    drain(200);

    // 20 + 3/16, applied by a resync that coincides with a period end (no tick there)
    t = m_base;
    goto(t + 1);
    bif.cfg_int  = 16'd20;
    bif.cfg_frac = 4'd3;
    bif.cfg_load = 1'b1;
    push_tick(2);
    goto(t + 2);
    bif.cfg_load = 1'b0;
    check("pending_before_resync", int'(bif.cfg_pending), 1);
    goto(t + 3);
    bif.resync = 1'b1;
    goto(t + 4);
    bif.resync = 1'b0;
    check("pending_cleared_by_resync", int'(bif.cfg_pending), 0);
    m_base = t + 4;
    m_ovs  = 0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) push_tick(frac_len[i]);
    drain(1500);

    // Resync 5 cycles into a period at int=10
    t = m_base;
    goto(t + 1);
    bif.cfg_int  = 16'd10;
    bif.cfg_frac = 4'd0;
    bif.cfg_load = 1'b1;
    goto(t + 2);
    bif.cfg_load = 1'b0;
    goto(t + 5);
    bif.resync = 1'b1;
    goto(t + 6);
    bif.resync = 1'b0;
    check("pending_after_resync10", int'(bif.cfg_pending), 0);
    m_base = t + 6;
    m_ovs  = 0;
    for (int i = 0; i < 16; i++) push_tick(10);
    drain(400);

    // Freeze for 50 cycles mid-period; a load while frozen applies without stretching the period
    t = m_base;
    goto(t + 4);
    bif.enable = 1'b0;
    goto(t + 10);
    bif.cfg_int  = 16'd12;
    bif.cfg_load = 1'b1;
    goto(t + 11);
    bif.cfg_load = 1'b0;
    check("pending_load_frozen", int'(bif.cfg_pending), 1);
    goto(t + 12);
    check("pending_apply_frozen", int'(bif.cfg_pending), 0);
    goto(t + 54);
    bif.enable = 1'b1;
    m_base = t + 50;
    push_tick(10);
    for (int i = 0; i < 4; i++) push_tick(12);
    drain(200);

    // Reset pulse mid-bit with a load in flight: defaults return, shadow dropped
    t = m_base;
    goto(t + 3);
    bif.cfg_int  = 16'd30;
    bif.cfg_load = 1'b1;
    goto(t + 4);
    bif.cfg_load = 1'b0;
    check("pending_before_reset", int'(bif.cfg_pending), 1);
    goto(t + 6);
    reset_n = 1'b0;
    #1;
    check("async_rst_pending", int'(bif.cfg_pending), 0);
    goto(t + 8);
    check("rst2_ovs_tick", int'(bif.ovs_tick), 0);
    check("rst2_mid_tick", int'(bif.mid_tick), 0);
    check("rst2_bit_tick", int'(bif.bit_tick), 0);
    reset_n = 1'b1;
    m_base  = t + 8;
    m_ovs   = 0;
    push_tick(325);
    push_tick(326);
    drain(800);

    goto(m_base + 20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised fractional baud-tick generator for the UART Tx/Rx paths.
- Divides the system clock by a runtime-programmable fractional divisor (integer + FRAC_W-bit fraction) to produce a one-cycle oversample tick.
- Derives from that tick a bit-rate tick and a mid-bit sample tick.
- Supports glitch-free divisor reload at tick boundaries, enable/freeze, and a resync input for Rx start-bit alignment.

Parameters:
- DIV_W, 16, width of integer divisor field.
- FRAC_W, 4, width of fractional divisor field; fraction unit is 1/2^FRAC_W clock.
- OVS, 16, oversample ticks per bit; must be even and >= 4.
- DEF_INT, 325, integer divisor loaded at reset (50 MHz, 16x9600).
- DEF_FRAC, 8, fractional divisor loaded at reset (8/16 = 0.5).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = run; 0 = freeze all counters and suppress ticks.
- cfg_int  in  DIV_W  requested integer divisor.
- cfg_frac  in  FRAC_W  requested fractional divisor.
- cfg_load  in  1  one-cycle strobe; captures cfg_int/cfg_frac into shadow.
- resync  in  1  one-cycle strobe; restarts period, fraction and oversample phase.
- cfg_pending  out  1  shadow captured but not yet active.
- ovs_tick  out  1  one-cycle pulse per oversample period.
- mid_tick  out  1  one-cycle pulse at mid-bit (coincides with an ovs_tick).
- bit_tick  out  1  one-cycle pulse per bit period (coincides with an ovs_tick).

Behaviour:
- Reset: active divisor = DEF_INT/DEF_FRAC; shadow = same. Period counter, fraction accumulator and oversample counter are 0. cfg_pending, ovs_tick, mid_tick and bit_tick are 0.
- Effective integer divisor N = max(active_int, 2). Values 0 and 1 are clamped to 2.
- Period counter counts enabled cycles from 0. ovs_tick is registered and asserted for one cycle when a period completes.
- Period length is N cycles, or N+1 cycles when acc + active_frac >= 2^FRAC_W (carry).
- The accumulator updates at each period end: acc <= (acc + frac) mod 2^FRAC_W. The carry decision for a period uses the acc value at that period's start.
- Long-run average period is N + frac/2^FRAC_W. Over 2^FRAC_W consecutive periods, the total is exactly 2^FRAC_W*N + frac cycles.
- Oversample counter counts ovs_tick modulo OVS.
  - bit_tick asserts with the ovs_tick that takes the counter from OVS-1 to 0.
  - mid_tick asserts with the ovs_tick that takes the counter from OVS/2-1 to OVS/2.
- enable=0: all counters, accumulator and outputs hold; ticks forced 0; cfg_load is still accepted. Removing enable resumes mid-period with no lost cycles.
- cfg_load: shadow <= cfg_int/cfg_frac and cfg_pending <= 1 on the next edge. A new cfg_load while pending overwrites the shadow; the last value wins.
- Apply rule: the shadow is copied to active and cfg_pending clears on the same edge as any of:
  - a period completes (ovs_tick asserted);
  - resync;
  - enable=0.
  The new divisor governs the following period; the current period is never truncated or stretched.
- cfg_load in the same cycle as an apply: the new values are captured and cfg_pending stays 1 for the next boundary.
- resync: period counter, acc and oversample counter go to 0, and no tick is issued that cycle. The first ovs_tick follows N (or N+1) enabled cycles later. The first mid_tick comes at tick OVS/2 and the first bit_tick at tick OVS. resync has priority over a coincident period completion.
- reset_n asserted mid-operation: all state returns to reset values immediately. The in-flight shadow is discarded.

Test Plan:
- Default config, enable=1 from reset: ovs_tick periods alternate 325/326. 16 consecutive ticks span 5208 cycles. bit_tick every 5208 cycles. mid_tick on ovs_tick 8 of each bit.
- cfg_int=10, cfg_frac=0 load: after the current period ends, ovs_tick exactly every 10 cycles and bit_tick every 160. cfg_pending is high from the load edge until that boundary.
- cfg_int=0 and cfg_int=1 (frac=0): ovs_tick every 2 cycles (clamp).
- cfg_int=20, cfg_frac=3 with FRAC_W=4: 16 periods sum to 323 cycles, exactly 3 periods are 21 cycles long, and the pattern repeats.
- resync issued 5 cycles into a period at int=10: no tick that cycle; next ovs_tick 10 cycles later; bit_tick 160 cycles after resync.
- enable low for 50 cycles mid-period, plus reset_n pulse mid-bit: no ticks while disabled and period resumes where frozen. After reset, outputs are 0 and DEF_INT/DEF_FRAC are active.
